// File: rtl/layer_weight_streamer.sv
// layer_weight_streamer
//
// Streams one complete convolution weight set from a word-addressed memory into
// the weight input of a conv engine. A start pulse in IDLE issues
// W = KERNEL*KERNEL*CHANNEL_NUM_IN*CHANNEL_NUM_OUT reads at ascending addresses
// from BASE_ADDR. The layout is output channel outermost, then input channel,
// then kernel row, then kernel column, so a plain incrementing address gives
// that order. Read data arrives one cycle after the read strobe. It is
// registered once more before it is presented, which gives a two-cycle
// read-to-output latency. pause suspends issuing reads without losing reads
// already in flight.
//
// Optional feature (macro LAYER_WEIGHT_STREAMER_BIAS_EN):
//   adds parameter BIAS_ADDR and the ports valid_bias_out/bias_out. After the
//   last weight read, CHANNEL_NUM_OUT bias words are read from BIAS_ADDR upward
//   and are emitted on the bias port.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   start            request one full weight stream (accepted in IDLE only)
//   pause            while high, no new reads are issued
//   mem_rd_en        memory read strobe
//   mem_addr         memory word address (wraps modulo 2^ADDR_WIDTH)
//   mem_data         read data, valid one cycle after mem_rd_en
//   valid_weight_out qualifies weight_out
//   weight_out       streamed weight word (0 when not valid)
//   busy             FSM not in IDLE
//   done             one-cycle pulse after the last emitted word
//   valid_bias_out   qualifies bias_out            (bias build only)
//   bias_out         streamed bias word            (bias build only)

module layer_weight_streamer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CHANNEL_NUM_IN  = 64,
  parameter int unsigned CHANNEL_NUM_OUT = 64,
  parameter int unsigned KERNEL          = 3,
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned BASE_ADDR       = 0
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  ,
  parameter int unsigned BIAS_ADDR       = 0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  busy,
  output logic                  done
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  ,
  output logic                  valid_bias_out,
  output logic [DATA_WIDTH-1:0] bias_out
`endif
);

  localparam int unsigned W     = KERNEL * KERNEL * CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int unsigned CNT_W = (W < 2) ? 1 : $clog2(W + 1);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  localparam int unsigned BCNT_W = (CHANNEL_NUM_OUT < 2) ? 1 : $clog2(CHANNEL_NUM_OUT + 1);

  localparam logic [BCNT_W-1:0]     BCNT_LAST = BCNT_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [BCNT_W-1:0]     BCNT_ONE  = BCNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] BIAS      = ADDR_WIDTH'(BIAS_ADDR);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    ,
    BIAS
`endif
  } state_t;

  state_t state;
  state_t state_next;

  // Number of weight reads issued so far in this stream.
  logic [CNT_W-1:0] count;

  // mem_rd_en delayed by one cycle. It marks the cycle in which mem_data holds
  // a word that has to be captured.
  logic rd_d1;

`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  logic [BCNT_W-1:0] bcount;
  // Tags the in-flight read as a bias word so that it goes to the bias port.
  logic              rd_bias_d1;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!pause && (count == CNT_LAST)) begin
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
          state_next = BIAS;
`else
          state_next = DRAIN;
`endif
        end
      end
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
      BIAS: begin
        if (!pause && (bcount == BCNT_LAST)) begin
          state_next = DRAIN;
        end
      end
`endif
      // On DRAIN entry, rd_d1 is high for the last read. Once it drops, the
      // last word is being presented in this cycle, so DONE follows it.
      DRAIN: begin
        if (!rd_d1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd_en = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    if ((state == LOAD) || (state == BIAS)) begin
      mem_rd_en = !pause;
    end
`else
    if (state == LOAD) begin
      mem_rd_en = !pause;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Counters and address
  //
  // mem_addr is kept as a register that advances with each issued read. It
  // therefore always equals BASE_ADDR + count (modulo 2^ADDR_WIDTH) and does not
  // need an adder on the output path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      mem_addr <= '0;
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
      bcount   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            mem_addr <= BASE;
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
            bcount   <= '0;
`endif
          end
        end
        LOAD: begin
          if (!pause) begin
            count <= count + CNT_ONE;
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
            if (count == CNT_LAST) begin
              mem_addr <= BIAS;
              bcount   <= '0;
            end else begin
              mem_addr <= mem_addr + ADDR_ONE;
            end
`else
            mem_addr <= mem_addr + ADDR_ONE;
`endif
          end
        end
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
        BIAS: begin
          if (!pause) begin
            bcount   <= bcount + BCNT_ONE;
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data pipeline
  //
  // A read in cycle N returns data in cycle N+1. The data is captured here and
  // presented in cycle N+2. Reset clears rd_d1, so no read that is in flight
  // when reset arrives is ever presented.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d1            <= 1'b0;
      valid_weight_out <= 1'b0;
      weight_out       <= '0;
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
      rd_bias_d1       <= 1'b0;
      valid_bias_out   <= 1'b0;
      bias_out         <= '0;
`endif
    end else begin
      rd_d1 <= mem_rd_en;
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
      rd_bias_d1       <= mem_rd_en && (state == BIAS);
      valid_weight_out <= rd_d1 && !rd_bias_d1;
      weight_out       <= (rd_d1 && !rd_bias_d1) ? mem_data : '0;
      valid_bias_out   <= rd_d1 && rd_bias_d1;
      bias_out         <= (rd_d1 && rd_bias_d1) ? mem_data : '0;
`else
      valid_weight_out <= rd_d1;
      weight_out       <= rd_d1 ? mem_data : '0;
`endif
    end
  end

endmodule

// File: tb/tb_layer_weight_streamer.sv
// Directed bench for layer_weight_streamer.
// The small instance uses KERNEL=1, CIN=2, COUT=2, BASE_ADDR=16 and
// BIAS_ADDR=100 in the bias build. The second instance uses default
// parameters. Each memory model returns its own address as the data word,
// one cycle after a read.

module tb_layer_weight_streamer;

`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  localparam int DONE_SHIFT = 2;   // two bias words precede done
`else
  localparam int DONE_SHIFT = 0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        pause;
  logic        s_rd_en;
  logic [19:0] s_addr;
  logic [31:0] s_mem_data;
  logic        s_v;
  logic [31:0] s_w;
  logic        s_busy;
  logic        s_done;

  logic        d_start;
  logic        d_pause;
  logic        d_rd_en;
  logic [19:0] d_addr;
  logic [31:0] d_mem_data;
  logic        d_v;
  logic [31:0] d_w;
  logic        d_busy;
  logic        d_done;

`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  logic        s_vb;
  logic [31:0] s_b;
  logic        d_vb;
  logic [31:0] d_b;
`endif

  int vectors;
  int miscompares;

  layer_weight_streamer #(
    .DATA_WIDTH(32),
    .CHANNEL_NUM_IN(2),
    .CHANNEL_NUM_OUT(2),
    .KERNEL(1),
    .ADDR_WIDTH(20),
    .BASE_ADDR(16)
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    ,
    .BIAS_ADDR(100)
`endif
  ) dut_s (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .mem_rd_en(s_rd_en),
    .mem_addr(s_addr),
    .mem_data(s_mem_data),
    .valid_weight_out(s_v),
    .weight_out(s_w),
    .busy(s_busy),
    .done(s_done)
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    ,
    .valid_bias_out(s_vb),
    .bias_out(s_b)
`endif
  );

  layer_weight_streamer dut_d (
    .clk(clk),
    .reset(reset),
    .start(d_start),
    .pause(d_pause),
    .mem_rd_en(d_rd_en),
    .mem_addr(d_addr),
    .mem_data(d_mem_data),
    .valid_weight_out(d_v),
    .weight_out(d_w),
    .busy(d_busy),
    .done(d_done)
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    ,
    .valid_bias_out(d_vb),
    .bias_out(d_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: data word = address, valid one cycle after a read
  always @(posedge clk) begin
    if (s_rd_en) s_mem_data <= {12'b0, s_addr};
    if (d_rd_en) d_mem_data <= {12'b0, d_addr};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({s_rd_en, s_v, s_busy, s_done} !== 4'b0 || s_addr !== 20'd0 || s_w !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_s: rd=%b v=%b busy=%b done=%b addr=%0d w=%0d want all 0",
               s_rd_en, s_v, s_busy, s_done, s_addr, s_w);
    end
    vectors++;
    if ({d_rd_en, d_v, d_busy, d_done} !== 4'b0 || d_addr !== 20'd0 || d_w !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_d: rd=%b v=%b busy=%b done=%b addr=%0d w=%0d want all 0",
               d_rd_en, d_v, d_busy, d_done, d_addr, d_w);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int exp_rd[7]   = '{0, 1, 1, 1, 1, -1, -1};
    int exp_addr[7] = '{-1, 16, 17, 18, 19, -1, -1};
    int exp_v[7]    = '{0, 0, 0, 1, 1, 1, 1};
    int exp_w[7]    = '{0, 0, 0, 16, 17, 18, 19};
    for (int i = 0; i < 7; i++) begin
      tick();
      start = (i == 0);
      #1;
      if (exp_rd[i] >= 0) begin
        vectors++;
        if (s_rd_en !== (exp_rd[i] != 0)) begin
          miscompares++;
          $display("FAIL basic_rd cyc %0d: got %b want %0d", i, s_rd_en, exp_rd[i]);
        end
      end
      if (exp_addr[i] >= 0) begin
        vectors++;
        if (s_addr !== 20'(exp_addr[i])) begin
          miscompares++;
          $display("FAIL basic_addr cyc %0d: got %0d want %0d", i, s_addr, exp_addr[i]);
        end
      end
      vectors++;
      if (s_v !== (exp_v[i] != 0) || s_w !== 32'(exp_w[i])) begin
        miscompares++;
        $display("FAIL basic_out cyc %0d: got v=%b w=%0d want v=%0d w=%0d",
                 i, s_v, s_w, exp_v[i], exp_w[i]);
      end
    end
    start = 1'b0;
    for (int j = 0; j <= DONE_SHIFT; j++) begin
      tick();
      #1;
      vectors++;
      if (s_v !== 1'b0 || s_done !== (j == DONE_SHIFT)) begin
        miscompares++;
        $display("FAIL basic_done tail %0d: got v=%b done=%b want v=0 done=%b",
                 j, s_v, s_done, (j == DONE_SHIFT));
      end
    end
    tick();
    #1;
    vectors++;
    if (s_done !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got done=%b busy=%b want 0 0", s_done, s_busy);
    end
  endtask

  task automatic test_pause();
    int pz[10]       = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int exp_rd[10]   = '{0, 1, 1, 0, 0, 0, 1, 1, -1, -1};
    int exp_addr[10] = '{-1, 16, 17, 18, 18, 18, 18, 19, -1, -1};
    int exp_v[10]    = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    int exp_w[10]    = '{0, 0, 0, 16, 17, 0, 0, 0, 18, 19};
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i == 0);
      pause = (pz[i] != 0);
      #1;
      if (exp_rd[i] >= 0) begin
        vectors++;
        if (s_rd_en !== (exp_rd[i] != 0)) begin
          miscompares++;
          $display("FAIL pause_rd cyc %0d: got %b want %0d", i, s_rd_en, exp_rd[i]);
        end
      end
      if (exp_addr[i] >= 0) begin
        vectors++;
        if (s_addr !== 20'(exp_addr[i])) begin
          miscompares++;
          $display("FAIL pause_addr cyc %0d: got %0d want %0d", i, s_addr, exp_addr[i]);
        end
      end
      vectors++;
      if (s_v !== (exp_v[i] != 0) || s_w !== 32'(exp_w[i]) || s_done !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_out cyc %0d: got v=%b w=%0d done=%b want v=%0d w=%0d done=0",
                 i, s_v, s_w, s_done, exp_v[i], exp_w[i]);
      end
    end
    start = 1'b0;
    pause = 1'b0;
    for (int j = 0; j <= DONE_SHIFT; j++) begin
      tick();
      #1;
      vectors++;
      if (s_v !== 1'b0 || s_done !== (j == DONE_SHIFT)) begin
        miscompares++;
        $display("FAIL pause_done tail %0d: got v=%b done=%b want v=0 done=%b",
                 j, s_v, s_done, (j == DONE_SHIFT));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_v[7] = '{0, 0, 0, 1, 1, 1, 1};
    int exp_w[7] = '{0, 0, 0, 16, 17, 18, 19};
    int nvalid = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      start = (i == 0) || (i == 2) || (i == 5) || (i == 6);
      #1;
      if (s_v === 1'b1) nvalid++;
      vectors++;
      if (s_v !== (exp_v[i] != 0) || s_w !== 32'(exp_w[i])) begin
        miscompares++;
        $display("FAIL b2b_out cyc %0d: got v=%b w=%0d want v=%0d w=%0d",
                 i, s_v, s_w, exp_v[i], exp_w[i]);
      end
    end
    for (int j = 0; j <= DONE_SHIFT; j++) begin
      tick();
      // Start pulsed in the DONE cycle must not be accepted
      start = (j == DONE_SHIFT);
      #1;
      if (s_v === 1'b1) nvalid++;
      vectors++;
      if (s_done !== (j == DONE_SHIFT)) begin
        miscompares++;
        $display("FAIL b2b_done tail %0d: got %b want %b", j, s_done, (j == DONE_SHIFT));
      end
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      start = 1'b0;
      #1;
      if (s_v === 1'b1) nvalid++;
      vectors++;
      if (s_busy !== 1'b0 || s_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_restart cyc %0d: got busy=%b rd=%b want 0 0", k, s_busy, s_rd_en);
      end
    end
    vectors++;
    if (nvalid != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words want 4", nvalid);
    end
  endtask

  task automatic test_reset_midstream();
    int exp_v[7] = '{0, 0, 0, 1, 1, 1, 1};
    int exp_w[7] = '{0, 0, 0, 16, 17, 18, 19};
    for (int i = 0; i < 5; i++) begin
      tick();
      start = (i == 0);
    end
    #1;
    vectors++;
    if (s_v !== 1'b1 || s_w !== 32'd17) begin
      miscompares++;
      $display("FAIL rst_pre: got v=%b w=%0d want v=1 w=17", s_v, s_w);
    end
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({s_rd_en, s_v, s_busy, s_done} !== 4'b0 || s_addr !== 20'd0 || s_w !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid: rd=%b v=%b busy=%b done=%b addr=%0d w=%0d want all 0",
               s_rd_en, s_v, s_busy, s_done, s_addr, s_w);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      vectors++;
      if (s_v !== 1'b0 || s_rd_en !== 1'b0 || s_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_after cyc %0d: got v=%b rd=%b busy=%b want 0 0 0",
                 k, s_v, s_rd_en, s_busy);
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      start = (i == 0);
      #1;
      vectors++;
      if (s_v !== (exp_v[i] != 0) || s_w !== 32'(exp_w[i])) begin
        miscompares++;
        $display("FAIL rst_restream cyc %0d: got v=%b w=%0d want v=%0d w=%0d",
                 i, s_v, s_w, exp_v[i], exp_w[i]);
      end
    end
    start = 1'b0;
    for (int j = 0; j <= DONE_SHIFT; j++) begin
      tick();
      #1;
      vectors++;
      if (s_done !== (j == DONE_SHIFT)) begin
        miscompares++;
        $display("FAIL rst_done tail %0d: got %b want %b", j, s_done, (j == DONE_SHIFT));
      end
    end
    tick();
  endtask

`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
  task automatic test_bias();
    int exp_rd[10]   = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int exp_addr[10] = '{-1, 16, 17, 18, 19, 100, 101, -1, -1, -1};
    int exp_v[10]    = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    int exp_vb[10]   = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    int exp_b[10]    = '{0, 0, 0, 0, 0, 0, 0, 100, 101, 0};
    int exp_d[10]    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i == 0);
      #1;
      vectors++;
      if (s_rd_en !== (exp_rd[i] != 0)) begin
        miscompares++;
        $display("FAIL bias_rd cyc %0d: got %b want %0d", i, s_rd_en, exp_rd[i]);
      end
      if (exp_addr[i] >= 0) begin
        vectors++;
        if (s_addr !== 20'(exp_addr[i])) begin
          miscompares++;
          $display("FAIL bias_addr cyc %0d: got %0d want %0d", i, s_addr, exp_addr[i]);
        end
      end
      vectors++;
      if (s_v !== (exp_v[i] != 0) || s_vb !== (exp_vb[i] != 0) ||
          s_b !== 32'(exp_b[i]) || s_done !== (exp_d[i] != 0)) begin
        miscompares++;
        $display("FAIL bias_out cyc %0d: got v=%b vb=%b b=%0d done=%b want v=%0d vb=%0d b=%0d done=%0d",
                 i, s_v, s_vb, s_b, s_done, exp_v[i], exp_vb[i], exp_b[i], exp_d[i]);
      end
    end
    start = 1'b0;
    tick();
  endtask
`endif

  task automatic test_default_full();
    int nvalid = 0;
    int ndone = 0;
    int first = -1;
    int last = -1;
    int bad_data = 0;
    int after_done = 0;
    bit finished = 1'b0;
    tick();
    d_start = 1'b1;
    for (int c = 1; c < 45000 && !finished; c++) begin
      tick();
      d_start = 1'b0;
      #1;
      if (d_v === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        if (d_w !== 32'(nvalid)) bad_data++;
        nvalid++;
      end
      if (d_done === 1'b1) ndone++;
      if (ndone > 0) begin
        after_done++;
        if (after_done > 4) finished = 1'b1;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL full_timeout: got no completion want done within 45000 cycles");
    end
    vectors++;
    if (nvalid != 36864) begin
      miscompares++;
      $display("FAIL full_count: got %0d want 36864", nvalid);
    end
    vectors++;
    if (ndone != 1) begin
      miscompares++;
      $display("FAIL full_done: got %0d pulses want 1", ndone);
    end
    vectors++;
    if (first != 3 || last - first + 1 != 36864) begin
      miscompares++;
      $display("FAIL full_span: got first=%0d span=%0d want first=3 span=36864",
               first, last - first + 1);
    end
    vectors++;
    if (bad_data != 0) begin
      miscompares++;
      $display("FAIL full_data: got %0d wrong words want 0", bad_data);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    d_start = 1'b0;
    d_pause = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_back_to_back();
    test_reset_midstream();
`ifdef LAYER_WEIGHT_STREAMER_BIAS_EN
    test_bias();
`endif
    test_default_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_weight_streamer.md
LAYER_WEIGHT_STREAMER -- requirements
Module: layer_weight_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the weight word width.
REQ-002 The block SHALL have parameter CHANNEL_NUM_IN, default 64, the input channels of the target conv.
REQ-003 The block SHALL have parameter CHANNEL_NUM_OUT, default 64, the output channels of the target conv.
REQ-004 The block SHALL have parameter KERNEL, default 3, the kernel side; the word count is W = KERNEL*KERNEL*CHANNEL_NUM_IN*CHANNEL_NUM_OUT, which is 36864 at defaults.
REQ-005 The block SHALL have parameter ADDR_WIDTH, default 20, the memory address width.
REQ-006 The block SHALL have parameter BASE_ADDR, default 0, the word address of the first weight.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 The block SHALL have port start, input, 1 bit, a request to stream one full weight set.
REQ-010 The block SHALL have port pause, input, 1 bit, which while high suspends issuing new reads.
REQ-011 The block SHALL have port mem_rd_en, output, 1 bit, the memory read strobe.
REQ-012 The block SHALL have port mem_addr, output, ADDR_WIDTH bits, the memory word address.
REQ-013 The block SHALL have port mem_data, input, DATA_WIDTH bits, read data valid exactly 1 cycle after mem_rd_en.
REQ-014 The block SHALL have port valid_weight_out, output, 1 bit, which qualifies weight_out and drives a conv valid_weight_in.
REQ-015 The block SHALL have port weight_out, output, DATA_WIDTH bits, the streamed weight word.
REQ-016 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-017 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, DRAIN, DONE, plus BIAS when the configuration macro is defined.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD, clear the read counter and set mem_addr to BASE_ADDR.
REQ-020 In LOAD, each cycle with pause=0 SHALL assert mem_rd_en, present mem_addr = BASE_ADDR + counter, and increment the counter by 1.
REQ-021 In LOAD, each cycle with pause=1 SHALL hold mem_rd_en=0 and leave the counter and mem_addr unchanged.
REQ-022 A read issued in the cycle before pause rises SHALL still be emitted on weight_out.
REQ-023 weight_out and valid_weight_out SHALL be registered: a mem_rd_en in cycle N produces valid_weight_out=1 and weight_out = the mem_data captured in cycle N+1, both in cycle N+2.
REQ-024 With pause held low, the first valid_weight_out SHALL appear 3 cycles after start is sampled.
REQ-025 With pause held low, valid_weight_out SHALL stay high for exactly W consecutive cycles.
REQ-026 Address order SHALL be output channel outermost, then input channel, then kernel row, then kernel column, as contiguous ascending addresses.
REQ-027 After the read with counter = W-1 is issued, the FSM SHALL enter DRAIN.
REQ-028 DRAIN SHALL wait until the last word has been emitted, then move to DONE.
REQ-029 DONE SHALL assert done for exactly one cycle, in the cycle after the last valid_weight_out, and then return to IDLE.
REQ-030 start SHALL be ignored while busy=1, with no restart and no queuing.
REQ-031 start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; start is accepted from IDLE only.
REQ-032 Exactly W words SHALL be emitted per start regardless of the pause pattern: no duplicates, no drops.
REQ-033 Each internal counter SHALL be sized to hold W; mem_addr SHALL wrap modulo 2^ADDR_WIDTH without an error flag.
REQ-034 valid_weight_out=0 SHALL force weight_out to 0.

Reset
REQ-035 Asserting reset SHALL immediately drive IDLE, zero all counters, and set mem_rd_en=0, mem_addr=0, valid_weight_out=0, weight_out=0, busy=0 and done=0.
REQ-036 Reset asserted mid-stream SHALL discard in-flight read data; no valid_weight_out follows reset release until a new start.

Configuration
REQ-037 When macro LAYER_WEIGHT_STREAMER_BIAS_EN is defined, the block SHALL add a parameter BIAS_ADDR and output ports valid_bias_out (1 bit) and bias_out (DATA_WIDTH bits).
REQ-038 With LAYER_WEIGHT_STREAMER_BIAS_EN defined, the FSM SHALL go LOAD -> BIAS after the last weight read and read CHANNEL_NUM_OUT words from BIAS_ADDR upward.
REQ-039 In BIAS, pause and latency SHALL follow the LOAD rules, and data SHALL be emitted on valid_bias_out/bias_out, never on valid_weight_out.
REQ-040 With LAYER_WEIGHT_STREAMER_BIAS_EN defined, the FSM SHALL enter DRAIN after the last bias read, and done SHALL follow the last valid_bias_out by 1 cycle.
REQ-041 Without LAYER_WEIGHT_STREAMER_BIAS_EN, the BIAS state, the BIAS_ADDR parameter and the bias ports SHALL not exist.

Verification
REQ-042 The bench SHALL cover: KERNEL=1, CIN=2, COUT=2, BASE_ADDR=16, memory word = address, start pulse -> mem_addr 16,17,18,19 and weight_out 16,17,18,19 on 4 consecutive valid cycles from start+3, done one cycle later.
REQ-043 The bench SHALL cover: the same config with pause=1 for 3 cycles after the 2nd read -> still exactly 4 words in order, a 3-cycle valid gap, done after the 4th word.
REQ-044 The bench SHALL cover: start re-pulsed while busy -> ignored, and exactly 4 words total.
REQ-045 The bench SHALL cover: reset asserted after the 2nd output word -> all outputs 0 immediately, no valid after release; a new start then streams words 16..19 again.
REQ-046 The bench SHALL cover: default parameters -> exactly 36864 valid_weight_out cycles and exactly one done pulse.
REQ-047 The bench SHALL cover: with LAYER_WEIGHT_STREAMER_BIAS_EN defined, COUT=2 and BIAS_ADDR=100 -> 4 weights, then bias_out 100,101, then done.
